// File: rtl/fft_input_framer_if.sv
// Sample-capture and FFT-core handshake bundle for the FFT input framer.
// The master side feeds samples and returns fft_done; the slave side is the framer.
interface fft_input_framer_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_real;
    logic [WIDTH-1:0]     in_imag;
    logic                 flush;
    logic                 fft_start;
    logic                 fft_done;
    logic [16*WIDTH-1:0]  x_par;
    logic                 busy;
    logic [15:0]          frame_count;
    logic                 timeout_err;

    modport master (
        output in_valid, in_real, in_imag, flush, fft_done,
        input  in_ready, fft_start, x_par, busy, frame_count, timeout_err
    );

    modport slave (
        input  in_valid, in_real, in_imag, flush, fft_done,
        output in_ready, fft_start, x_par, busy, frame_count, timeout_err
    );
endinterface

// File: rtl/fft_input_framer.sv
// Ping-pong serial-to-parallel framer: collects 8 complex samples per bank and
// launches the 8-point FFT core, holding the frame stable until it reports done.
module fft_input_framer #(
    parameter int WIDTH        = 16,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_input_framer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(DONE_TIMEOUT - 1);

    logic [WIDTH-1:0]    re_r [0:1][0:7];
    logic [WIDTH-1:0]    im_r [0:1][0:7];
    logic                wr_bank_r;
    logic                rd_bank_r;
    logic [2:0]          wr_idx_r;
    logic [1:0]          bank_full_r;
    state_t              state_r;
    state_t              state_nxt_s;
    logic [7:0]          cnt_r;
    logic                start_r;
    logic                busy_r;
    logic [15:0]         frame_count_r;
    logic                err_r;
    logic [16*WIDTH-1:0] x_par_r;

    logic                ready_s;
    logic                accept_s;
    logic                load_s;
    logic                timeout_s;
    logic [1:0]          set_mask_s;
    logic [1:0]          clr_mask_s;
    logic [16*WIDTH-1:0] frame_s;

    // Capture handshake and bank full/free bookkeeping masks
    always_comb begin
        ready_s    = ~bank_full_r[wr_bank_r];
        accept_s   = bus.in_valid & ready_s & ~bus.flush;
        set_mask_s = 2'b00;
        clr_mask_s = 2'b00;
        if (accept_s && (wr_idx_r == 3'd7)) begin
            set_mask_s = 2'b01 << wr_bank_r;
        end else begin
            set_mask_s = 2'b00;
        end
        if (load_s) begin
            clr_mask_s = 2'b01 << rd_bank_r;
        end else begin
            clr_mask_s = 2'b00;
        end
    end

    // Sample storage and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_r <= 1'b0;
            wr_idx_r  <= 3'd0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    re_r[b][i] <= '0;
                    im_r[b][i] <= '0;
                end
            end
        end else if (bus.flush) begin
            wr_bank_r <= 1'b0;
            wr_idx_r  <= 3'd0;
        end else if (accept_s) begin
            re_r[wr_bank_r][wr_idx_r] <= bus.in_real;
            im_r[wr_bank_r][wr_idx_r] <= bus.in_imag;
            wr_idx_r                  <= wr_idx_r + 3'd1;
            if (wr_idx_r == 3'd7) begin
                wr_bank_r <= ~wr_bank_r;
            end
        end
    end

    // Bank occupancy and read pointer; set and clear never hit the same bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full_r <= 2'b00;
            rd_bank_r   <= 1'b0;
        end else if (bus.flush) begin
            bank_full_r <= 2'b00;
            rd_bank_r   <= 1'b0;
        end else begin
            bank_full_r <= (bank_full_r | set_mask_s) & ~clr_mask_s;
            if (load_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
        end
    end

    // Read-bank view laid out as the core's parallel frame
    always_comb begin
        frame_s = '0;
        for (int k = 0; k < 8; k++) begin
            frame_s[2*k*WIDTH +: WIDTH]     = re_r[rd_bank_r][k];
            frame_s[(2*k+1)*WIDTH +: WIDTH] = im_r[rd_bank_r][k];
        end
    end

    // Launch FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bank_full_r[rd_bank_r]) begin
                    state_nxt_s = LAUNCH;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH: begin
                state_nxt_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.fft_done) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s = IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, wait counter and registered core-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= 8'd0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= 16'd0;
            err_r         <= 1'b0;
            x_par_r       <= '0;
        end else begin
            state_r <= state_nxt_s;
            start_r <= (state_nxt_s == LAUNCH);
            busy_r  <= (state_nxt_s != IDLE);
            cnt_r   <= (state_r == WAIT_DONE) ? (cnt_r + 8'd1) : 8'd0;
            if (state_r == LAUNCH) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end
            if (load_s) begin
                x_par_r <= frame_s;
            end
        end
    end

    assign bus.in_ready    = ready_s;
    assign bus.fft_start   = start_r;
    assign bus.busy        = busy_r;
    assign bus.frame_count = frame_count_r;
    assign bus.timeout_err = err_r;
    assign bus.x_par       = x_par_r;
endmodule

// File: tb/tb_fft_input_framer.sv
// Scoreboard bench for fft_input_framer: two instances (short and long done
// timeout) share one stimulus driver; sel picks which one is driven and observed.
module tb_fft_input_framer;
    localparam int W  = 16;
    localparam int FW = 16 * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_input_framer_if #(.WIDTH(W)) ifa ();
    fft_input_framer_if #(.WIDTH(W)) ifb ();

    fft_input_framer #(.WIDTH(W), .DONE_TIMEOUT(15))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    fft_input_framer #(.WIDTH(W), .DONE_TIMEOUT(255)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    logic         sel = 1'b0;
    logic         drv_valid = 1'b0;
    logic         drv_flush = 1'b0;
    logic         drv_done = 1'b0;
    logic [W-1:0] drv_re = '0;
    logic [W-1:0] drv_im = '0;

    assign ifa.in_valid = drv_valid & ~sel;
    assign ifb.in_valid = drv_valid & sel;
    assign ifa.flush    = drv_flush & ~sel;
    assign ifb.flush    = drv_flush & sel;
    assign ifa.fft_done = drv_done & ~sel;
    assign ifb.fft_done = drv_done & sel;
    assign ifa.in_real  = drv_re;
    assign ifb.in_real  = drv_re;
    assign ifa.in_imag  = drv_im;
    assign ifb.in_imag  = drv_im;

    logic          obs_ready, obs_start, obs_busy, obs_err;
    logic [15:0]   obs_fc;
    logic [FW-1:0] obs_x;
    assign obs_ready = sel ? ifb.in_ready    : ifa.in_ready;
    assign obs_start = sel ? ifb.fft_start   : ifa.fft_start;
    assign obs_busy  = sel ? ifb.busy        : ifa.busy;
    assign obs_err   = sel ? ifb.timeout_err : ifa.timeout_err;
    assign obs_fc    = sel ? ifb.frame_count : ifa.frame_count;
    assign obs_x     = sel ? ifb.x_par       : ifa.x_par;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_starts = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    logic          auto_done = 1'b0;
    logic          stalled = 1'b0;
    logic          prev_start = 1'b0;
    logic [FW-1:0] launched = '0;
    logic [FW-1:0] exp_q [$];
    logic [W-1:0]  m_re [8];
    logic [W-1:0]  m_im [8];
    int            m_idx = 0;

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Start monitor: pulse width and frame contents against the scoreboard
    initial forever begin
        logic [FW-1:0] exp;
        @(negedge clk);
        if (obs_start) begin
            n_starts++;
            start_cyc = cyc;
            launched  = obs_x;
            chk("start_width", {255'd0, prev_start}, {FW{1'b0}});
            if (exp_q.size() == 0) begin
                chk("unexpected_start", {255'd0, obs_start}, {FW{1'b0}});
            end else begin
                exp = exp_q.pop_front();
                chk("frame", obs_x, exp);
            end
        end
        prev_start = obs_start;
    end

    // Core model: answers fft_start with fft_done six cycles later
    initial forever begin
        @(negedge clk);
        if (obs_start && auto_done) begin
            repeat (5) @(negedge clk);
            chk("x_par_stable", obs_x, launched);
            drv_done = 1'b1;
            @(negedge clk);
            drv_done = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
        logic [FW-1:0] frame;
        int guard;
        guard = 0;
        drv_valid = 1'b1;
        drv_re = re;
        drv_im = im;
        while (!obs_ready && guard < 300) begin
            stalled = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("ready_wait", {255'd0, obs_ready}, {{255{1'b0}}, 1'b1});
        @(posedge clk);
        m_re[m_idx] = re;
        m_im[m_idx] = im;
        if (m_idx == 7) begin
            frame = '0;
            for (int k = 0; k < 8; k++) begin
                frame[2*k*W +: W]     = m_re[k];
                frame[(2*k+1)*W +: W] = m_im[k];
            end
            exp_q.push_back(frame);
            m_idx = 0;
        end else begin
            m_idx++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drv_valid = 1'b0;
        drv_flush = 1'b0;
        drv_done  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_start", {255'd0, obs_start}, {FW{1'b0}});
        chk("rst_busy",  {255'd0, obs_busy},  {FW{1'b0}});
        chk("rst_err",   {255'd0, obs_err},   {FW{1'b0}});
        chk("rst_fc",    {240'd0, obs_fc},    {FW{1'b0}});
        chk("rst_x_par", obs_x,               {FW{1'b0}});
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        n_starts = 0;
        m_idx = 0;
        stalled = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {255'd0, obs_ready}, {{255{1'b0}}, 1'b1});
    endtask

    task automatic wait_starts(input int n);
        int guard;
        guard = 0;
        while (n_starts < n && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("starts", FW'(n_starts), FW'(n));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (obs_busy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("idle", {255'd0, obs_busy}, {FW{1'b0}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int err_cyc;

        // Single frame with latency and entry 3 content
        sel = 1'b0; auto_done = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) send(W'(100 + k), W'(-k));
        drv_valid = 1'b0;
        chk("start_early", {255'd0, obs_start}, {FW{1'b0}});
        @(negedge clk);
        chk("start_latency", {255'd0, obs_start}, {{255{1'b0}}, 1'b1});
        chk("e3_real", FW'(obs_x[6*W +: W]), FW'(16'd103));
        chk("e3_imag", FW'(obs_x[7*W +: W]), FW'(16'hFFFD));
        wait_starts(1);
        wait_idle();
        chk("single_fc", FW'(obs_fc), FW'(16'd1));

        // Continuous stream of three frames
        do_reset();
        for (int k = 0; k < 24; k++) send(W'(k * 7 + 3), W'(~k));
        drv_valid = 1'b0;
        wait_starts(3);
        wait_idle();
        chk("stream_no_stall", {255'd0, stalled}, {FW{1'b0}});
        chk("stream_fc", FW'(obs_fc), FW'(16'd3));

        // Backpressure on the long-timeout instance
        sel = 1'b1; auto_done = 1'b0;
        do_reset();
        for (int k = 1; k <= 24; k++) send(W'(k), W'(-k));
        drv_valid = 1'b0;
        chk("bp_no_stall", {255'd0, stalled}, {FW{1'b0}});
        chk("bp_ready_low", {255'd0, obs_ready}, {FW{1'b0}});
        repeat (4) @(negedge clk);
        chk("bp_ready_held", {255'd0, obs_ready}, {FW{1'b0}});
        chk("bp_one_start", FW'(n_starts), FW'(1));
        drv_done = 1'b1;
        @(negedge clk);
        drv_done = 1'b0;
        auto_done = 1'b1;
        guard = 0;
        while (!obs_ready && guard < 2) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_ready_back", {255'd0, obs_ready}, {{255{1'b0}}, 1'b1});
        wait_starts(3);
        wait_idle();
        chk("bp_fc", FW'(obs_fc), FW'(16'd3));

        // Done timeout and sticky error
        sel = 1'b0; auto_done = 1'b0;
        do_reset();
        for (int k = 0; k < 16; k++) send(W'(16'h8000 + k), W'(16'h7FF0 - k));
        drv_valid = 1'b0;
        guard = 0;
        while (!obs_err && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        err_cyc = cyc;
        chk("to_set", {255'd0, obs_err}, {{255{1'b0}}, 1'b1});
        chk("to_delay", FW'(err_cyc - start_cyc), FW'(16));
        chk("to_idle", {255'd0, obs_busy}, {FW{1'b0}});
        wait_starts(2);
        @(negedge clk);
        chk("to_fc", FW'(obs_fc), FW'(16'd2));
        chk("to_sticky", {255'd0, obs_err}, {{255{1'b0}}, 1'b1});

        // Flush discards a partial frame
        auto_done = 1'b1;
        do_reset();
        for (int k = 1; k <= 5; k++) send(W'(k), W'(k));
        drv_valid = 1'b0;
        drv_flush = 1'b1;
        @(negedge clk);
        drv_flush = 1'b0;
        m_idx = 0;
        chk("flush_ready", {255'd0, obs_ready}, {{255{1'b0}}, 1'b1});
        for (int k = 0; k < 8; k++) send(W'(200 + k), W'(k));
        drv_valid = 1'b0;
        wait_starts(1);
        chk("flush_e0", FW'(obs_x[0 +: W]), FW'(16'd200));
        wait_idle();
        repeat (3) @(negedge clk);
        chk("flush_one_launch", FW'(n_starts), FW'(1));
        chk("flush_fc", FW'(obs_fc), FW'(16'd1));

        // Reset while waiting with the other bank full
        auto_done = 1'b0;
        do_reset();
        for (int k = 0; k < 16; k++) send(W'(300 + k), W'(-300 - k));
        drv_valid = 1'b0;
        chk("mid_busy", {255'd0, obs_busy}, {{255{1'b0}}, 1'b1});
        do_reset();
        auto_done = 1'b1;
        for (int k = 0; k < 8; k++) send(W'(400 + k), W'(k * 3));
        drv_valid = 1'b0;
        wait_starts(1);
        wait_idle();
        chk("mid_fc", FW'(obs_fc), FW'(16'd1));
        chk("mid_queue", FW'(exp_q.size()), FW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
